// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// uart_tx_pkg : shared types and helpers for the configurable UART transmitter
// Rev 1.0
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Serial bit times in one frame: start + payload + optional parity + 1 or 2 stops.
    function automatic int unsigned frame_bits(input int unsigned data_width,
                                               input logic        par_en,
                                               input logic        stop2);
        return 32'd2 + data_width + {31'd0, par_en} + {31'd0, stop2};
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// ============================================================================
// uart_tx_cfg_if : word/handshake bundle between the byte source and the UART TX
// Rev 1.0
// ============================================================================
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Data_Ready;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        output STOP2,
        input  Data_Ready
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        input  STOP2,
        output Data_Ready
    );

endinterface : uart_tx_cfg_if
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// uart_baud_gen : prescale counter issuing one tick every i_presc clocks
// Rev 1.0
// ============================================================================
module uart_baud_gen #(
    parameter int PRESC_W = 6
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_restart,
    input  wire logic [PRESC_W-1:0] i_presc,
    output logic                    o_tick
);

    logic [PRESC_W-1:0] r_cnt;
    logic [PRESC_W-1:0] w_term;

    // A prescale of zero is treated as one so the line can never stall.
    assign w_term = (i_presc == '0) ? '0 : (i_presc - PRESC_W'(1));
    assign o_tick = (r_cnt == w_term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PRESC_W'(1);
        end
    end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// uart_tx_cfg : parametrised UART transmitter with prescaler and holding buffer
// Rev 1.0
// ============================================================================
module uart_tx_cfg
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  wire logic               clk,
    input  wire logic               rst,
    uart_tx_cfg_if.slave            s_if,
    input  wire logic [PRESC_W-1:0] Prescale,
    output logic                    TX_OUT,
    output logic                    busy
);

    localparam int                 c_IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    // Holding buffer
    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic                  r_buf_par_en;
    logic                  r_buf_par_typ;
    logic                  r_buf_stop2;

    // Frame currently on the line
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stop2;
    logic [PRESC_W-1:0]    r_presc;

    tx_state_e             r_state;
    tx_state_e             w_state_nxt;
    logic [c_IDX_W-1:0]    r_bit_idx;
    logic [c_IDX_W-1:0]    w_bit_idx_nxt;
    logic                  r_stop_idx;
    logic                  w_stop_idx_nxt;

    logic                  r_tx;
    logic                  r_busy;
    logic                  w_tx_nxt;

    logic                  w_tick;
    logic                  w_accept;
    logic                  w_stop_last;
    logic                  w_load;
    logic                  w_parity;

    assign w_accept    = s_if.Data_Valid && !r_buf_full;
    assign w_stop_last = (r_stop_idx == r_stop2);
    // A waiting word is loaded either from idle or on the final tick of the
    // last stop bit, which is what makes chained frames gap-free.
    assign w_load      = r_buf_full &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_tick && w_stop_last));
    assign w_parity    = (r_par_typ == PAR_ODD) ? ~^r_data : ^r_data;

    assign s_if.Data_Ready = ~r_buf_full;
    assign TX_OUT          = r_tx;
    assign busy            = r_busy;

    uart_baud_gen #(
        .PRESC_W (PRESC_W)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_load),
        .i_presc   (r_presc),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_full    <= 1'b0;
            r_buf_data    <= '0;
            r_buf_par_en  <= 1'b0;
            r_buf_par_typ <= PAR_EVEN;
            r_buf_stop2   <= 1'b0;
        end else if (w_accept) begin
            r_buf_full    <= 1'b1;
            r_buf_data    <= s_if.P_DATA;
            r_buf_par_en  <= s_if.PAR_EN;
            r_buf_par_typ <= s_if.PAR_TYP;
            r_buf_stop2   <= s_if.STOP2;
        end else if (w_load) begin
            r_buf_full    <= 1'b0;
        end
    end

    // Frame settings, including the prescaler, stay frozen for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
            r_stop2   <= 1'b0;
            r_presc   <= '0;
        end else if (w_load) begin
            r_data    <= r_buf_data;
            r_par_en  <= r_buf_par_en;
            r_par_typ <= r_buf_par_typ;
            r_stop2   <= r_buf_stop2;
            r_presc   <= Prescale;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_tx_nxt       = 1'b1;

        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (w_tick) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = '0;
                end
            end
            DATA: begin
                w_tx_nxt = r_data[r_bit_idx];
                if (w_tick) begin
                    if (r_bit_idx == c_LAST_IDX) begin
                        w_state_nxt    = r_par_en ? PARITY : STOP;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + c_IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                w_tx_nxt = w_parity;
                if (w_tick) begin
                    w_state_nxt    = STOP;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                if (w_tick) begin
                    if (w_stop_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt    = START;
            w_bit_idx_nxt  = '0;
            w_stop_idx_nxt = 1'b0;
        end
    end

    // Line level and busy are registered from the current state, so both lag
    // the state by one clock and stay aligned with each other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_nxt;
            r_busy <= (r_state != IDLE);
        end
    end

endmodule : uart_tx_cfg
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_cfg : self-checking bench for uart_tx_cfg (8-bit and 5-bit instances)
// Rev 1.0
// ============================================================================
module tb_uart_tx_cfg;
    import uart_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] presc8;
    logic [5:0] presc5;
    logic       tx8, busy8, tx5, busy5;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    bit chk_done = 1'b0;
    bit exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_cfg_if #(.DATA_WIDTH(8)) if8 ();
    uart_tx_cfg_if #(.DATA_WIDTH(5)) if5 ();

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESC_W(6)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .s_if     (if8),
        .Prescale (presc8),
        .TX_OUT   (tx8),
        .busy     (busy8)
    );

    uart_tx_cfg #(.DATA_WIDTH(5), .PRESC_W(6)) dut5 (
        .clk      (clk),
        .rst      (rst),
        .s_if     (if5),
        .Prescale (presc5),
        .TX_OUT   (tx5),
        .busy     (busy5)
    );

    function automatic logic tx_of(input bit u5);   return u5 ? tx5 : tx8;   endfunction
    function automatic logic busy_of(input bit u5); return u5 ? busy5 : busy8; endfunction
    function automatic logic rdy_of(input bit u5);  return u5 ? if5.Data_Ready : if8.Data_Ready; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the line level for every clock of a frame, built bit by bit.
    function automatic void add_frame(input int dw, input logic [8:0] d, input bit pe,
                                      input bit pt, input bit s2, input int p);
        int peff = (p == 0) ? 1 : p;
        int ones = 0;
        bit lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            lv.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) lv.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
        lv.push_back(1'b1);
        if (s2) lv.push_back(1'b1);
        foreach (lv[i]) repeat (peff) exp_q.push_back(lv[i]);
    endfunction

    task automatic send(input bit u5, input logic [8:0] d, input bit pe, input bit pt,
                        input bit s2, input logic [5:0] p, output int acc);
        int n = 0;
        if (u5) begin
            if5.P_DATA = d[4:0]; if5.PAR_EN = pe; if5.PAR_TYP = pt; if5.STOP2 = s2;
            if5.Data_Valid = 1'b1;
        end else begin
            if8.P_DATA = d[7:0]; if8.PAR_EN = pe; if8.PAR_TYP = pt; if8.STOP2 = s2;
            if8.Data_Valid = 1'b1;
        end
        while (!rdy_of(u5) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 400), 1);
        // Prescale changes only once the previous word has left the buffer.
        if (u5) presc5 = p; else presc8 = p;
        acc = cyc + 1;
        @(negedge clk);
        if (u5) if5.Data_Valid = 1'b0; else if8.Data_Valid = 1'b0;
        chk("ready_drop", rdy_of(u5), 0);
    endtask

    task automatic watch(input bit u5, input string tag, output int start);
        int n = 0;
        bit e;
        start = -1;
        while (!busy_of(u5) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 32'(n < 300), 1);
        if (n < 300) begin
            start = cyc;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_line"}, {30'd0, busy_of(u5), tx_of(u5)}, {30'd0, 1'b1, e});
                @(negedge clk);
            end
            chk({tag, "_idle"}, {30'd0, busy_of(u5), tx_of(u5)}, 32'd1);
        end
        exp_q.delete();
        chk_done = 1'b1;
    endtask

    task automatic run_one(input bit u5, input logic [8:0] d, input bit pe, input bit pt,
                           input bit s2, input logic [5:0] p, input string tag);
        int acc, st;
        add_frame(u5 ? 5 : 8, d, pe, pt, s2, int'(p));
        chk_done = 1'b0;
        fork
            send(u5, d, pe, pt, s2, p, acc);
            watch(u5, tag, st);
        join
        chk({tag, "_latency"}, 32'(st - acc), 2);
    endtask

    task automatic run_pair(input bit u5,
                            input logic [8:0] d1, input bit pe1, input bit pt1, input bit s21,
                            input logic [5:0] p1,
                            input logic [8:0] d2, input bit pe2, input bit pt2, input bit s22,
                            input logic [5:0] p2, input bit scramble, input string tag);
        int a1, a2, st, k, len1;
        len1 = int'(frame_bits(u5 ? 5 : 8, pe1, s21)) * ((p1 == 0) ? 1 : int'(p1));
        add_frame(u5 ? 5 : 8, d1, pe1, pt1, s21, int'(p1));
        add_frame(u5 ? 5 : 8, d2, pe2, pt2, s22, int'(p2));
        chk_done = 1'b0;
        fork
            begin
                send(u5, d1, pe1, pt1, s21, p1, a1);
                send(u5, d2, pe2, pt2, s22, p2, a2);
                k = 0;
                while (scramble && !chk_done && k < 600) begin
                    if (u5) begin
                        if5.P_DATA = 5'($urandom); if5.PAR_TYP = 1'($urandom);
                        if5.STOP2 = 1'($urandom); if5.PAR_EN = 1'($urandom);
                    end else begin
                        if8.P_DATA = 8'($urandom); if8.PAR_TYP = 1'($urandom);
                        if8.STOP2 = 1'($urandom); if8.PAR_EN = 1'($urandom);
                    end
                    @(negedge clk);
                    k++;
                end
            end
            watch(u5, tag, st);
        join
        chk({tag, "_latency"}, 32'(st - a1), 2);
        chk({tag, "_accept_midframe"}, 32'(a2 < st + len1), 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        presc8 = 6'd1; presc5 = 6'd1;
        if8.P_DATA = '0; if8.Data_Valid = 1'b0; if8.PAR_EN = 1'b0; if8.PAR_TYP = 1'b0; if8.STOP2 = 1'b0;
        if5.P_DATA = '0; if5.Data_Valid = 1'b0; if5.PAR_EN = 1'b0; if5.PAR_TYP = 1'b0; if5.STOP2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx8, 1);
        chk("reset_busy", busy8, 0);
        chk("reset_ready", if8.Data_Ready, 1);
        chk("reset_ready5", if5.Data_Ready, 1);
        rst = 1'b1;
        @(negedge clk);

        // 0x0A, even parity, single stop, one clock per bit
        run_one(1'b0, 9'h00A, 1'b1, PAR_EVEN, 1'b0, 6'd1, "t1");
        // 0x08, no parity, two stops, four clocks per bit
        run_one(1'b0, 9'h008, 1'b0, PAR_EVEN, 1'b1, 6'd4, "t2");
        // 0x64 then 0x17 odd, chained, source inputs scrambled after capture
        run_pair(1'b0, 9'h064, 1'b0, PAR_EVEN, 1'b0, 6'd1,
                       9'h017, 1'b1, PAR_ODD,  1'b0, 6'd1, 1'b1, "t3");
        repeat (2) @(negedge clk);

        // Asynchronous reset during data bit 3 of 0x55
        begin
            int acc;
            send(1'b0, 9'h055, 1'b0, PAR_EVEN, 1'b0, 6'd2, acc);
            repeat (10) @(negedge clk);
            chk("t5_bit3_line", {30'd0, busy8, tx8}, {30'd0, 1'b1, 1'b0});
            #2 rst = 1'b0;
            #1;
            chk("t5_rst_tx", tx8, 1);
            chk("t5_rst_busy", busy8, 0);
            chk("t5_rst_ready", if8.Data_Ready, 1);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
        end
        run_one(1'b0, 9'h055, 1'b1, PAR_ODD, 1'b0, 6'd2, "t5_after");

        // 5-bit instance, odd parity, prescale 0 behaves as 1
        run_one(1'b1, 9'h01F, 1'b1, PAR_ODD, 1'b0, 6'd0, "t6");

        for (int r = 0; r < 6; r++) begin
            run_one(1'b0, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    6'($urandom_range(0, 4)), "rand8");
        end
        for (int r = 0; r < 3; r++) begin
            run_pair(1'b1, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                           6'($urandom_range(0, 3)),
                           9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                           6'($urandom_range(0, 3)), 1'($urandom), "rand5_pair");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_cfg
`default_nettype wire
